word_sample_sequencer: RTL and testbench
========================================

# word_sample_sequencer

Playback sequencer sitting directly downstream of the word-code-to-base-address stage. It accepts an 8-bit base address (word code × 8, codes 1..20 → bases 0..152) and fetches the word's 8 consecutive samples from an external synchronous sample ROM. It then streams the samples one at a time to the audio output stage over a valid/ready handshake, and signals completion.

## Interface
Parameters:
- WORD_LEN, 8: samples per word; the base stride equals WORD_LEN.
- MAX_BASE, 152: highest legal base address.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; samples base_in. Honoured only in IDLE.
- base_in  input  8  base address from the upstream stage.
- rom_addr  output  8  registered address to the sample ROM.
- rom_data  input  8  ROM read data; valid the cycle after rom_addr changes (1-cycle latency).
- sample_out  output  8  registered sample to downstream.
- sample_valid  output  1  sample_out is valid.
- sample_ready  input  1  downstream accepts the sample on an edge where valid and ready are both high.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse after the last sample is accepted.
- err  output  1  one-cycle pulse when start is rejected.

## Operation
FSM states: IDLE, WAIT, CAPT, HOLD. Sample index idx is 3 bits, 0..7.

- **IDLE, start=1, valid base:** a base is valid when base_in[2:0]==0 and base_in ≤ MAX_BASE. On the edge: rom_addr←base_in, idx←0, next state WAIT.
- **IDLE, start=1, invalid base:** err←1 for one cycle. State stays IDLE. No ROM access occurs.
- **Base 0 is legal** (word 1). It is not treated as "no word".
- **WAIT:** the ROM registers its data. Next state CAPT unconditionally.
- **CAPT:** sample_out←rom_data, sample_valid←1. Next state HOLD.
- **HOLD:** sample_out and sample_valid stay stable until handshake.
  - Handshake with idx<7: sample_valid←0, idx←idx+1, rom_addr←rom_addr+1, next state WAIT.
  - Handshake with idx==7: sample_valid←0, done←1, next state IDLE.
- **start while busy:** ignored. No err, no effect on the stream.
- **Address arithmetic:** 8-bit. The maximum reached is 152+7=159, so no wrap is possible for legal bases.
- **sample_ready outside HOLD:** ignored.
- **Reset (asynchronous, any state, including mid-stream):** state←IDLE, rom_addr←0, sample_out←0, sample_valid←0, idx←0, done←0, err←0. busy therefore reads 0. A partially streamed word is abandoned and not resumed.

## Timing
- **Start to first sample:** start accepted at edge E0 → rom_addr valid after E0 → ROM data valid after E1 → sample_valid high after E2.
- **Throughput:** with sample_ready held high, 3 cycles per sample. A full word takes 24 cycles from the accept edge to the last handshake.
- **done:** high exactly one cycle, starting the edge after the final handshake. It coincides with IDLE, so a new start is accepted in that same cycle.
- **err:** high exactly one cycle after the rejecting edge.
- **Back-pressure:** each cycle of ready low in HOLD extends the stream by exactly one cycle. sample_out must not change while valid && !ready.

## Structure
- Shared package holds:
  - WORD_LEN, MAX_BASE and the base stride constant.
  - The state enum (IDLE, WAIT, CAPT, HOLD), 2-bit encoding.
  - The base-legality check as a function, reused by the upstream stage's testbench.
- No sub-module; the FSM, index counter and output registers form one block. The sample ROM is external.

## Test plan
ROM model for all scenarios: rom_data = rom_addr ^ 8'hA5, registered with 1-cycle latency.

- **Nominal word:** start with base_in=16, ready=1 → samples 0xB5,0xB4,0xB7,0xB6,0xB1,0xB0,0xB3,0xB2 at 3-cycle spacing. First valid 3 edges after accept; done pulses once after 0xB2; busy high 24 cycles.
- **Top and bottom words:** base_in=152 → rom_addr 0x98..0x9F, samples 0x3D..0x3A, no wrap. base_in=0 → samples 0xA5..0xA2 and no err.
- **Invalid base:** start with base_in=12, then 160 → err pulses one cycle each, busy stays 0, rom_addr unchanged, no sample_valid.
- **Back-pressure:** base_in=40, ready low for 5 cycles on sample 3 → sample_out holds 0x8E (43^A5) for all 5 cycles; total stream length is 29 cycles; order is intact.
- **Start while busy, then back-to-back:** pulse start with base_in=64 mid-stream of base 8 → ignored, base 8 completes normally. Start with 64 in the done cycle → accepted immediately; first sample 0xE5.
- **Reset mid-stream:** assert rst low during HOLD of sample 4 → all outputs 0 asynchronously. After release, start with base_in=24 plays 0xBD..0xBA from idx 0.

Source files
------------

// File: rtl/word_sample_sequencer_pkg.sv
// Shared constants, state encoding and base-legality check for the word
// sample playback sequencer and its neighbouring stages.
package word_sample_sequencer_pkg;

  localparam int unsigned WORD_LEN    = 8;
  localparam int unsigned MAX_BASE    = 152;
  localparam int unsigned BASE_STRIDE = WORD_LEN;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned SAMPLE_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    HOLD = 2'd3
  } state_e;

  // A base is legal when it is stride-aligned and no higher than the last word.
  // Base 0 is word 1 and is legal.
  function automatic logic base_is_legal(
    input logic [ADDR_W-1:0] base,
    input int unsigned       max_base = MAX_BASE,
    input int unsigned       stride   = BASE_STRIDE
  );
    logic [31:0] base_w;
    base_w = 32'(base);
    return ((base_w % stride) == 32'd0) && (base_w <= max_base);
  endfunction

endpackage

// File: rtl/word_sample_sequencer.sv
// Fetches WORD_LEN consecutive samples from an external 1-cycle-latency ROM
// and streams them out one at a time over a valid/ready handshake.
module word_sample_sequencer
  import word_sample_sequencer_pkg::*;
#(
  parameter int unsigned WORD_LEN = word_sample_sequencer_pkg::WORD_LEN,
  parameter int unsigned MAX_BASE = word_sample_sequencer_pkg::MAX_BASE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_in,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_data,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned IDX_W = $clog2(WORD_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);

  state_e              state_q,    state_d;
  logic [IDX_W-1:0]    idx_q,      idx_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [SAMPLE_W-1:0] sample_q,   sample_d;
  logic                valid_q,    valid_d;
  logic                done_q,     done_d;
  logic                err_q,      err_d;

  logic handshake;
  assign handshake = valid_q && sample_ready;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rom_addr_d = rom_addr_q;
    sample_d   = sample_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (base_is_legal(base_in, MAX_BASE, WORD_LEN)) begin
            rom_addr_d = base_in;
            idx_d      = '0;
            state_d    = WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT: state_d = CAPT;
      CAPT: begin
        sample_d = rom_data;
        valid_d  = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        // sample_out is left untouched at the handshake; only valid drops.
        if (handshake) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rom_addr_q <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_word_sample_sequencer.sv
// Directed bench for word_sample_sequencer with a registered ROM model
// (data = addr ^ 8'hA5, 1-cycle latency).
module tb_word_sample_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base_in;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       sample_ready;
  logic       busy;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] hs_data[$];
  logic [7:0] hs_addr[$];
  logic [7:0] stall_vals[$];
  int first_valid_e, last_hs_e, done_e, done_cnt, busy_cnt, err_cnt;
  bit timed_out;

  word_sample_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_in      (base_in),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_addr ^ 8'hA5;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Plays one word. Edge e counts edges after the accept edge E0; outputs are
  // observed 2 time units after each edge and inputs for the next edge set then.
  task automatic run_word(input logic [7:0] base, input int stall_idx,
                          input int stall_len, input int mid_start_e,
                          input int abort_idx);
    int stall_left;
    hs_data.delete();
    hs_addr.delete();
    stall_vals.delete();
    first_valid_e = -1; last_hs_e = -1; done_e = -1;
    done_cnt = 0; busy_cnt = 0; err_cnt = 0; timed_out = 1'b0;
    stall_left = stall_len;
    start = 1'b1; base_in = base; sample_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e <= 60; e++) begin
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (done) begin
        done_e = e;
        done_cnt++;
        return;
      end
      start = 1'b0;
      if (e == mid_start_e) begin
        start = 1'b1;
        base_in = 8'd64;
      end
      if (sample_valid) begin
        if (first_valid_e < 0) first_valid_e = e;
        if (hs_data.size() == abort_idx) begin
          sample_ready = 1'b0;
          return;
        end
        if (hs_data.size() == stall_idx && stall_left > 0) begin
          stall_vals.push_back(sample_out);
          stall_left--;
          sample_ready = 1'b0;
        end else begin
          sample_ready = 1'b1;
          hs_data.push_back(sample_out);
          hs_addr.push_back(rom_addr);
          last_hs_e = e + 1;
        end
      end
      tick();
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    start = 1'b0; base_in = 8'd0; sample_ready = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({busy, sample_valid, done, err, rom_addr, sample_out} !== 20'h0) begin
      failures++;
      $display("FAIL reset_async: got %05h expected 00000",
               {busy, sample_valid, done, err, rom_addr, sample_out});
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, sample_valid, done, err, rom_addr, sample_out} !== 20'h0) begin
      failures++;
      $display("FAIL reset_release_idle: got %05h expected 00000",
               {busy, sample_valid, done, err, rom_addr, sample_out});
    end
  endtask

  task automatic test_invalid();
    logic [7:0] bad[2];
    bad[0] = 8'd12;
    bad[1] = 8'd160;
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; base_in = bad[k];
      tick();
      start = 1'b0;
      checks++;
      if (err !== 1'b1) begin
        failures++;
        $display("FAIL invalid_err_pulse[%0d]: got %b expected 1", bad[k], err);
      end
      checks++;
      if ({busy, sample_valid, rom_addr} !== 10'h0) begin
        failures++;
        $display("FAIL invalid_no_access[%0d]: got %03h expected 000",
                 bad[k], {busy, sample_valid, rom_addr});
      end
      tick();
      checks++;
      if ({err, busy, sample_valid} !== 3'b000) begin
        failures++;
        $display("FAIL invalid_err_clear[%0d]: got %b expected 000",
                 bad[k], {err, busy, sample_valid});
      end
    end
  endtask

  task automatic test_nominal();
    logic [7:0] exp_data[8] = '{8'hB5, 8'hB4, 8'hB7, 8'hB6, 8'hB1, 8'hB0, 8'hB3, 8'hB2};
    run_word(8'd16, -1, 0, -1, -1);
    checks++;
    if (timed_out || hs_data.size() != 8) begin
      failures++;
      $display("FAIL nominal_count: got %0d samples timeout=%0d expected 8 timeout=0",
               hs_data.size(), timed_out);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hs_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL nominal_data[%0d]: got %02h expected %02h", i, hs_data[i], exp_data[i]);
      end
    end
    checks++;
    if (first_valid_e != 2 || last_hs_e != 24 || done_e != 24 || busy_cnt != 24) begin
      failures++;
      $display("FAIL nominal_timing: got first=%0d last=%0d done=%0d busy=%0d expected 2 24 24 24",
               first_valid_e, last_hs_e, done_e, busy_cnt);
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL nominal_done_single: got done,busy=%b expected 00", {done, busy});
    end
  endtask

  task automatic test_top_bottom();
    logic [7:0] exp_b;
    run_word(8'd152, -1, 0, -1, -1);
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'd152 + 8'(i);
      checks++;
      if (hs_addr[i] !== exp_b || hs_data[i] !== (exp_b ^ 8'hA5)) begin
        failures++;
        $display("FAIL top_word[%0d]: got addr=%02h data=%02h expected addr=%02h data=%02h",
                 i, hs_addr[i], hs_data[i], exp_b, exp_b ^ 8'hA5);
      end
    end
    checks++;
    if (done_e != 24) begin
      failures++;
      $display("FAIL top_done: got %0d expected 24", done_e);
    end
    tick();
    run_word(8'd0, -1, 0, -1, -1);
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'(i);
      checks++;
      if (hs_data[i] !== (exp_b ^ 8'hA5)) begin
        failures++;
        $display("FAIL bottom_data[%0d]: got %02h expected %02h", i, hs_data[i], exp_b ^ 8'hA5);
      end
    end
    checks++;
    if (err_cnt != 0 || done_cnt != 1 || done_e != 24) begin
      failures++;
      $display("FAIL bottom_status: got err=%0d done=%0d done_e=%0d expected 0 1 24",
               err_cnt, done_cnt, done_e);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_data[8] = '{8'h8D, 8'h8C, 8'h8F, 8'h8E, 8'h89, 8'h88, 8'h8B, 8'h8A};
    run_word(8'd40, 3, 5, -1, -1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hs_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL bp_data[%0d]: got %02h expected %02h", i, hs_data[i], exp_data[i]);
      end
    end
    checks++;
    if (stall_vals.size() != 5) begin
      failures++;
      $display("FAIL bp_stall_len: got %0d expected 5", stall_vals.size());
    end
    foreach (stall_vals[i]) begin
      checks++;
      if (stall_vals[i] !== 8'h8E) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got %02h expected 8e", i, stall_vals[i]);
      end
    end
    checks++;
    if (last_hs_e != 29 || busy_cnt != 29 || done_e != 29) begin
      failures++;
      $display("FAIL bp_length: got last=%0d busy=%0d done=%0d expected 29 29 29",
               last_hs_e, busy_cnt, done_e);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b;
    run_word(8'd8, -1, 0, 10, -1);
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'd8 + 8'(i);
      checks++;
      if (hs_data[i] !== (exp_b ^ 8'hA5)) begin
        failures++;
        $display("FAIL busy_start_data[%0d]: got %02h expected %02h", i, hs_data[i], exp_b ^ 8'hA5);
      end
    end
    checks++;
    if (err_cnt != 0 || done_e != 24) begin
      failures++;
      $display("FAIL busy_start_status: got err=%0d done_e=%0d expected 0 24", err_cnt, done_e);
    end
    run_word(8'd64, -1, 0, -1, -1);
    checks++;
    if (hs_data[0] !== 8'hE5 || first_valid_e != 2 || busy_cnt != 24) begin
      failures++;
      $display("FAIL b2b_first: got data=%02h first=%0d busy=%0d expected e5 2 24",
               hs_data[0], first_valid_e, busy_cnt);
    end
    checks++;
    if (hs_data[7] !== 8'hE2 || done_e != 24) begin
      failures++;
      $display("FAIL b2b_last: got data=%02h done_e=%0d expected e2 24", hs_data[7], done_e);
    end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    logic [7:0] exp_b;
    run_word(8'd80, -1, 0, -1, 4);
    checks++;
    if (hs_data.size() != 4 || sample_valid !== 1'b1 || sample_out !== 8'hF1) begin
      failures++;
      $display("FAIL mid_pre_reset: got n=%0d valid=%b out=%02h expected 4 1 f1",
               hs_data.size(), sample_valid, sample_out);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({busy, sample_valid, done, err, rom_addr, sample_out} !== 20'h0) begin
      failures++;
      $display("FAIL mid_reset_async: got %05h expected 00000",
               {busy, sample_valid, done, err, rom_addr, sample_out});
    end
    sample_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    run_word(8'd24, -1, 0, -1, -1);
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'd24 + 8'(i);
      checks++;
      if (hs_data[i] !== (exp_b ^ 8'hA5)) begin
        failures++;
        $display("FAIL post_reset_data[%0d]: got %02h expected %02h", i, hs_data[i], exp_b ^ 8'hA5);
      end
    end
    checks++;
    if (hs_data.size() != 8 || done_e != 24 || hs_addr[0] !== 8'd24) begin
      failures++;
      $display("FAIL post_reset_status: got n=%0d done_e=%0d addr0=%02h expected 8 24 18",
               hs_data.size(), done_e, hs_addr[0]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_invalid();
    test_nominal();
    test_top_bottom();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
